// File: rtl/riscv_mul_pkg.sv
// Shared definitions for the execute-stage multiply path: widths, decoder
// mulctrl encodings and the issue-controller state set.
package riscv_mul_pkg;

  localparam int XLEN = 64;
  localparam int REGW = 5;

  localparam logic [3:0] MULCTRL_MUL    = 4'b1100;
  localparam logic [3:0] MULCTRL_MULH   = 4'b1101;
  localparam logic [3:0] MULCTRL_MULHU  = 4'b1110;
  localparam logic [3:0] MULCTRL_MULHSU = 4'b1111;
  localparam logic [3:0] MULCTRL_MULW   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/riscv_mul_issue_ctrl.sv
// Execute-stage front end for the sequential multiplier: holds operands stable,
// stalls the pipe while the product is pending and absorbs flushes mid-flight.
module riscv_mul_issue_ctrl #(
  parameter int XLEN = riscv_mul_pkg::XLEN,
  parameter int REGW = riscv_mul_pkg::REGW
) (
  input  logic            i_riscv_mul_clk,
  input  logic            i_riscv_mul_rst,
  input  logic [3:0]      i_riscv_mulis_ctrl,
  input  logic [XLEN-1:0] i_riscv_mulis_rs1data,
  input  logic [XLEN-1:0] i_riscv_mulis_rs2data,
  input  logic [REGW-1:0] i_riscv_mulis_rd,
  input  logic            i_riscv_mulis_flush,
  output logic            o_riscv_mulis_stall,
  output logic [XLEN-1:0] o_riscv_mulis_result,
  output logic [REGW-1:0] o_riscv_mulis_rd,
  output logic            o_riscv_mulis_valid,
  output logic [XLEN-1:0] o_riscv_mulis_mul_rs1,
  output logic [XLEN-1:0] o_riscv_mulis_mul_rs2,
  output logic [3:0]      o_riscv_mulis_mul_ctrl,
  input  logic [XLEN-1:0] i_riscv_mulis_mul_product,
  input  logic            i_riscv_mulis_mul_valid
);
  import riscv_mul_pkg::*;

  mul_state_e      r_state;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [3:0]      r_ctrl;
  logic [REGW-1:0] r_rd;
  logic [XLEN-1:0] r_result;
  logic [REGW-1:0] r_res_rd;

  logic w_req;
  logic w_accept;
  logic w_in_flight;

  assign w_req       = i_riscv_mulis_ctrl[3];
  assign w_accept    = (r_state == IDLE) && w_req && !i_riscv_mulis_flush;
  assign w_in_flight = (r_state == BUSY) || (r_state == DRAIN);

  always_ff @(posedge i_riscv_mul_clk or posedge i_riscv_mul_rst) begin
    if (i_riscv_mul_rst) begin
      r_state  <= IDLE;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_ctrl   <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_res_rd <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rs1   <= i_riscv_mulis_rs1data;
            r_rs2   <= i_riscv_mulis_rs2data;
            r_ctrl  <= i_riscv_mulis_ctrl;
            r_rd    <= i_riscv_mulis_rd;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (i_riscv_mulis_mul_valid) begin
            r_result <= i_riscv_mulis_mul_product;
            r_res_rd <= r_rd;
            r_state  <= i_riscv_mulis_flush ? IDLE : DONE;
          end else if (i_riscv_mulis_flush) begin
            r_state <= DRAIN;
          end
        end
        // The multiplier cannot abort, so a killed op must still run to its valid.
        DRAIN: begin
          if (i_riscv_mulis_mul_valid) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ctrl stays asserted through the valid cycle because it picks the product slice.
  assign o_riscv_mulis_mul_rs1  = r_rs1;
  assign o_riscv_mulis_mul_rs2  = r_rs2;
  assign o_riscv_mulis_mul_ctrl = w_in_flight ? r_ctrl : 4'b0000;

  assign o_riscv_mulis_stall = w_accept
                            || (r_state == BUSY)
                            || ((r_state == DRAIN) && w_req);

  assign o_riscv_mulis_valid  = (r_state == DONE) && !i_riscv_mulis_flush;
  assign o_riscv_mulis_result = r_result;
  assign o_riscv_mulis_rd     = r_res_rd;

endmodule

// File: tb/tb_riscv_mul_issue_ctrl.sv
// Bench for riscv_mul_issue_ctrl with a behavioural 64-bit sequential multiplier
// beside it; expected results are queued at issue and checked by a monitor.
module tb_riscv_mul_issue_ctrl;
  import riscv_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ctrl;
  logic [63:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        o_stall, o_valid;
  logic [63:0] o_result, o_mul_rs1, o_mul_rs2;
  logic [4:0]  o_rd;
  logic [3:0]  o_mul_ctrl;
  logic [63:0] m_prod;
  logic        m_valid;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          vcyc;
  } exp_t;
  exp_t q[$];

  riscv_mul_issue_ctrl dut (
    .i_riscv_mul_clk          (clk),
    .i_riscv_mul_rst          (rst),
    .i_riscv_mulis_ctrl       (ctrl),
    .i_riscv_mulis_rs1data    (rs1),
    .i_riscv_mulis_rs2data    (rs2),
    .i_riscv_mulis_rd         (rd),
    .i_riscv_mulis_flush      (flush),
    .o_riscv_mulis_stall      (o_stall),
    .o_riscv_mulis_result     (o_result),
    .o_riscv_mulis_rd         (o_rd),
    .o_riscv_mulis_valid      (o_valid),
    .o_riscv_mulis_mul_rs1    (o_mul_rs1),
    .o_riscv_mulis_mul_rs2    (o_mul_rs2),
    .o_riscv_mulis_mul_ctrl   (o_mul_ctrl),
    .i_riscv_mulis_mul_product(m_prod),
    .i_riscv_mulis_mul_valid  (m_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V multiply semantics computed on 128-bit extended operands.
  function automatic logic [63:0] ref_product(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    case (c)
      4'b1100: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      4'b1101: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'b1110: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      4'b1111: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      4'b1000: begin p = {96'b0, a[31:0]} * {96'b0, b[31:0]}; return {{32{p[31]}}, p[31:0]}; end
      default: return 64'd0;
    endcase
  endfunction

  // Companion multiplier: starts on ctrl[3], one-cycle valid 66 cycles later.
  logic        m_busy;
  int          m_cnt;
  logic [63:0] m_hold;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; m_valid <= 1'b0; m_prod <= '0; m_hold <= '0;
    end else begin
      m_valid <= 1'b0;
      if (!m_busy && o_mul_ctrl[3] && !m_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
        m_hold <= ref_product(o_mul_ctrl, o_mul_rs1, o_mul_rs2);
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 65) begin
          m_valid <= 1'b1;
          m_prod  <= m_hold;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", o_result, e.res);
        chk("rd", {59'b0, o_rd}, {59'b0, e.rd});
        chk("valid_cycle", 64'(cyc), 64'(e.vcyc));
      end
    end
  end

  // Present one op from IDLE and hold it in EX until stall drops.
  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] d, input logic [63:0] er);
    int t0;
    int n;
    ctrl = c; rs1 = a; rs2 = b; rd = d; flush = 1'b0;
    t0 = cyc;
    q.push_back('{er, d, t0 + 68});
    n = 0;
    @(negedge clk);
    while (o_stall && n < 300) begin
      if (cyc - t0 == 1) chk("mul_ctrl_busy", {60'b0, o_mul_ctrl}, {60'b0, c});
      n++;
      @(negedge clk);
    end
    chk("stall_len", 64'(cyc - t0), 64'd68);
    chk("mul_ctrl_done", {60'b0, o_mul_ctrl}, 64'd0);
    @(posedge clk); #1;
    ctrl = 4'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {63'b0, o_stall}, 64'd0);
    chk({tag, "_valid"}, {63'b0, o_valid}, 64'd0);
    chk({tag, "_result"}, o_result, 64'd0);
    chk({tag, "_rd"}, {59'b0, o_rd}, 64'd0);
    chk({tag, "_mulrs1"}, o_mul_rs1, 64'd0);
    chk({tag, "_mulrs2"}, o_mul_rs2, 64'd0);
    chk({tag, "_mulctrl"}, {60'b0, o_mul_ctrl}, 64'd0);
  endtask

  logic [3:0] codes [8] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

  initial begin
    int t0;
    int n;
    rst = 1'b1; ctrl = '0; rs1 = '0; rs2 = '0; rd = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;

    issue(MULCTRL_MUL, 64'd3, -64'sd5, 5'd7, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(MULCTRL_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(MULCTRL_MULW, 64'h7FFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE);

    // Flush at cycle 10, then a mulh waits out the drain.
    ctrl = MULCTRL_MUL; rs1 = 64'd11; rs2 = 64'd13; rd = 5'd4; flush = 1'b0;
    t0 = cyc;
    repeat (10) @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    ctrl = MULCTRL_MULH; rs1 = 64'h4000_0000_0000_0000; rs2 = 64'd4; rd = 5'd12;
    q.push_back('{64'd1, 5'd12, t0 + 136});
    @(negedge clk);
    chk("drain_stall", {63'b0, o_stall}, 64'd1);
    chk("drain_mul_ctrl", {60'b0, o_mul_ctrl}, {60'b0, MULCTRL_MUL});
    n = 0;
    while (o_stall && n < 300) begin n++; @(negedge clk); end
    chk("flush_resume_cycle", 64'(cyc - t0), 64'd136);
    @(posedge clk); #1;
    ctrl = 4'b0;

    issue(MULCTRL_MUL, 64'd2, 64'd3, 5'd1, 64'd6);
    issue(MULCTRL_MUL, 64'd4, 64'd5, 5'd2, 64'd20);

    // Asynchronous reset mid-operation.
    ctrl = MULCTRL_MULH; rs1 = 64'h1234_5678_9ABC_DEF0; rs2 = 64'h0FED_CBA9_8765_4321; rd = 5'd30;
    q.push_back('{64'd0, 5'd30, cyc + 68});
    repeat (30) @(posedge clk);
    #3;
    rst = 1'b1; ctrl = 4'b0;
    q.delete();
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(MULCTRL_MUL, 64'd7, 64'd6, 5'd5, 64'd42);

    for (int i = 0; i < 6; i++) begin
      logic [3:0]  c;
      logic [63:0] a, b;
      c = codes[$urandom_range(0, 7)];
      a = {$urandom, $urandom};
      b = (i == 0) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      issue(c, a, b, 5'($urandom), ref_product(c, a, b));
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) chk("pending_results", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
